host_bus_master: RTL

HOST_BUS_MASTER -- requirements
Module: host_bus_master

---
 rtl/host_bus_master.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/host_bus_master.sv
// ============================================================================
//  Module   : host_bus_master
//  Purpose  : Single-outstanding command master for an asynchronous SRAM-style
//             host bus with parameterised setup / strobe / hold timing.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module host_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        nRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [20:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [15:0] rsp_rdata,
  output logic        HOST_nCS,
  output logic        HOST_nWE,
  output logic        HOST_nOE,
  output logic [20:0] HOST_ADD,
  output logic [15:0] HOST_WDATA,
  output logic        HOST_DOE,
  input  logic [15:0] HOST_RDATA
);

  // Counter reload values: each phase counts down to zero, so load N-1.
  localparam logic [7:0] c_SETUP_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] c_STROBE_LAST = 8'(STROBE_CYC - 1);
  localparam logic [7:0] c_HOLD_LAST   = 8'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        write_q;
  logic        cmd_ready_q;
  logic        rsp_valid_q;
  logic        rsp_write_q;
  logic [15:0] rsp_rdata_q;
  logic        ncs_q;
  logic        nwe_q;
  logic        noe_q;
  logic        doe_q;
  logic [20:0] add_q;
  logic [15:0] wdata_q;

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      write_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= 16'd0;
      ncs_q       <= 1'b1;
      nwe_q       <= 1'b1;
      noe_q       <= 1'b1;
      doe_q       <= 1'b0;
      add_q       <= 21'd0;
      wdata_q     <= 16'd0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // cmd_ready is low straight out of reset; raise it before accepting.
          if (!cmd_ready_q) begin
            cmd_ready_q <= 1'b1;
          end else if (cmd_valid) begin
            cmd_ready_q <= 1'b0;
            write_q     <= cmd_write;
            add_q       <= cmd_addr;
            ncs_q       <= 1'b0;
            doe_q       <= cmd_write;
            if (cmd_write) begin
              wdata_q <= cmd_wdata;
            end
            cnt_q   <= c_SETUP_LAST;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_q == 8'd0) begin
            nwe_q   <= !write_q;
            noe_q   <= write_q;
            cnt_q   <= c_STROBE_LAST;
            state_q <= ST_STROBE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_STROBE: begin
          if (cnt_q == 8'd0) begin
            nwe_q <= 1'b1;
            noe_q <= 1'b1;
            // Sampled at the edge closing the strobe to allow for a registered responder.
            if (!write_q) begin
              rsp_rdata_q <= HOST_RDATA;
            end
            cnt_q   <= c_HOLD_LAST;
            state_q <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == 8'd0) begin
            ncs_q       <= 1'b1;
            doe_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= write_q;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_write  = rsp_write_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign HOST_nCS   = ncs_q;
  assign HOST_nWE   = nwe_q;
  assign HOST_nOE   = noe_q;
  assign HOST_DOE   = doe_q;
  assign HOST_ADD   = add_q;
  assign HOST_WDATA = wdata_q;

endmodule

`default_nettype wire
